// File: rtl/mem_responder.sv
// Memory-side responder for the fetch/decoder handshake: one read or write at a
// time, programmable wait states, word and halfword accesses to a single-port SRAM.
module mem_responder #(
    parameter int ADDR_WIDTH    = 16,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  read_en_in,
    input  logic                  write_en_in,
    input  logic                  word_select_in,
    input  logic [31:0]           write_data_in,
    output logic [31:0]           read_data_out,
    output logic                  mem_busy_out,
    output logic                  mem_output_valid_out,
    output logic                  mem_write_ready_out,
    output logic [ADDR_WIDTH-3:0] sram_addr_out,
    output logic                  sram_cs_out,
    output logic                  sram_we_out,
    output logic [3:0]            sram_be_out,
    output logic [31:0]           sram_wdata_out,
    input  logic [31:0]           sram_rdata_in
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] RD_WAIT_CYCLES = CW'(READ_LATENCY - 2);
    localparam logic [CW-1:0] WR_WAIT_CYCLES = CW'(WRITE_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE, RD_WAIT, RD_ACCESS, RD_DONE, WR_WAIT, WR_ACCESS
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [ADDR_WIDTH-3:0] word_addr_reg, word_addr_next;
    logic                  half_hi_reg, half_hi_next;
    logic                  half_reg, half_next;
    logic [31:0]           wd_reg, wd_next;
    logic [31:0]           hold_reg;
    logic                  busy_reg, valid_reg, ready_reg, cs_reg, we_reg;
    logic [3:0]            be_reg, be_next;
    logic [31:0]           sram_wdata_reg, sram_wdata_next;
    logic                  can_accept;
    logic [31:0]           rd_fmt;

    // Byte-within-halfword bit is never needed; halfwords are aligned down.
    logic addr_lsb_unused;
    assign addr_lsb_unused = addr_in[0];

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        word_addr_next = word_addr_reg;
        half_hi_next   = half_hi_reg;
        half_next      = half_reg;
        wd_next        = wd_reg;
        can_accept     = (state_reg == IDLE) || (state_reg == RD_DONE) || (state_reg == WR_ACCESS);

        case (state_reg)
            RD_WAIT: begin
                if (cnt_reg == CW'(1)) state_next = RD_ACCESS;
                else                   cnt_next   = cnt_reg - CW'(1);
            end
            WR_WAIT: begin
                if (cnt_reg == CW'(1)) state_next = WR_ACCESS;
                else                   cnt_next   = cnt_reg - CW'(1);
            end
            RD_ACCESS: state_next = RD_DONE;
            default:   state_next = IDLE;
        endcase

        // A new request overrides the fall-back to IDLE, giving bubble-free back-to-back.
        if (can_accept && (read_en_in || write_en_in)) begin
            word_addr_next = addr_in[ADDR_WIDTH-1:2];
            half_hi_next   = addr_in[1];
            half_next      = word_select_in;
            wd_next        = write_data_in;
            if (write_en_in) begin
                cnt_next   = WR_WAIT_CYCLES;
                state_next = (WRITE_LATENCY == 1) ? WR_ACCESS : WR_WAIT;
            end else begin
                cnt_next   = RD_WAIT_CYCLES;
                state_next = (READ_LATENCY == 2) ? RD_ACCESS : RD_WAIT;
            end
        end

        be_next         = 4'b0000;
        sram_wdata_next = 32'h0;
        if (state_next == RD_ACCESS) begin
            be_next = 4'b1111;
        end else if (state_next == WR_ACCESS) begin
            if (half_next) begin
                be_next         = half_hi_next ? 4'b1100 : 4'b0011;
                sram_wdata_next = {wd_next[15:0], wd_next[15:0]};
            end else begin
                be_next         = 4'b1111;
                sram_wdata_next = wd_next;
            end
        end
    end

    assign rd_fmt = half_reg ? {16'h0, half_hi_reg ? sram_rdata_in[31:16] : sram_rdata_in[15:0]}
                             : sram_rdata_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            word_addr_reg  <= '0;
            half_hi_reg    <= 1'b0;
            half_reg       <= 1'b0;
            wd_reg         <= 32'h0;
            hold_reg       <= 32'h0;
            busy_reg       <= 1'b0;
            valid_reg      <= 1'b0;
            ready_reg      <= 1'b0;
            cs_reg         <= 1'b0;
            we_reg         <= 1'b0;
            be_reg         <= 4'b0000;
            sram_wdata_reg <= 32'h0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            word_addr_reg  <= word_addr_next;
            half_hi_reg    <= half_hi_next;
            half_reg       <= half_next;
            wd_reg         <= wd_next;
            if (state_reg == RD_DONE) hold_reg <= rd_fmt;
            busy_reg       <= (state_next == RD_WAIT) || (state_next == RD_ACCESS) || (state_next == WR_WAIT);
            valid_reg      <= (state_next == RD_DONE);
            ready_reg      <= (state_next == WR_ACCESS);
            cs_reg         <= (state_next == RD_ACCESS) || (state_next == WR_ACCESS);
            we_reg         <= (state_next == WR_ACCESS);
            be_reg         <= be_next;
            sram_wdata_reg <= sram_wdata_next;
        end
    end

    // SRAM data only arrives during RD_DONE, so that cycle bypasses the hold register.
    assign read_data_out        = (state_reg == RD_DONE) ? rd_fmt : hold_reg;
    assign mem_busy_out         = busy_reg;
    assign mem_output_valid_out = valid_reg;
    assign mem_write_ready_out  = ready_reg;
    assign sram_addr_out        = word_addr_reg;
    assign sram_cs_out          = cs_reg;
    assign sram_we_out          = we_reg;
    assign sram_be_out          = be_reg;
    assign sram_wdata_out       = sram_wdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latencies 2/1 and 4/3), each with an SRAM
// model, checked cycle by cycle against a transaction-level reference model.
module tb_mem_responder;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          mem_init;
    logic [AW-1:0] addr [2];
    logic          rd [2], wr [2], ws [2];
    logic [31:0]   wd [2];
    logic [31:0]   rdo [2];
    logic          busy [2], valid [2], ready [2], cs [2], we [2];
    logic [AW-3:0] saddr [2];
    logic [3:0]    be [2];
    logic [31:0]   swd [2];

    function automatic logic [31:0] init_word(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic [31:0] rdata_q;
        logic [31:0] mem [256];

        mem_responder #(
            .ADDR_WIDTH   (AW),
            .READ_LATENCY (gi == 0 ? 2 : 4),
            .WRITE_LATENCY(gi == 0 ? 1 : 3)
        ) u_dut (
            .clk                 (clk),
            .reset               (reset),
            .addr_in             (addr[gi]),
            .read_en_in          (rd[gi]),
            .write_en_in         (wr[gi]),
            .word_select_in      (ws[gi]),
            .write_data_in       (wd[gi]),
            .read_data_out       (rdo[gi]),
            .mem_busy_out        (busy[gi]),
            .mem_output_valid_out(valid[gi]),
            .mem_write_ready_out (ready[gi]),
            .sram_addr_out       (saddr[gi]),
            .sram_cs_out         (cs[gi]),
            .sram_we_out         (we[gi]),
            .sram_be_out         (be[gi]),
            .sram_wdata_out      (swd[gi]),
            .sram_rdata_in       (rdata_q)
        );

        always @(posedge clk) begin
            if (mem_init) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            end else if (cs[gi]) begin
                if (we[gi]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[gi][b]) mem[saddr[gi][7:0]][8*b +: 8] <= swd[gi][8*b +: 8];
                end else begin
                    rdata_q <= mem[saddr[gi][7:0]];
                end
            end
        end
    end

    // Reference model: current transaction kind (0 none, 1 read, 2 write) and
    // cycle index k since its accept edge; it completes when k reaches its latency.
    int            m_kind [2];
    int            m_k [2];
    logic [15:0]   m_addr [2];
    logic          m_ws [2];
    logic [31:0]   m_wd [2];
    logic [31:0]   m_hold [2];
    logic [31:0]   ref_mem [2][256];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat(int id, int kind);
        if (kind == 1) return (id == 0) ? 2 : 4;
        return (id == 0) ? 1 : 3;
    endfunction

    task automatic set_req(input int id, input logic r, input logic w, input logic [15:0] a,
                           input logic s, input logic [31:0] d);
        rd[id] = r; wr[id] = w; addr[id] = a; ws[id] = s; wd[id] = d;
    endtask

    task automatic set_idle(input int id);
        set_req(id, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0);
    endtask

    // Check this cycle's outputs against the model, advance the model over the
    // coming rising edge, then move to the next falling edge.
    task automatic step(input int id);
        int          kind, k, len;
        logic [31:0] word, fmt, e_wd, e_rd;
        logic [3:0]  e_be;
        logic        e_cs, e_we, done;
        kind = m_kind[id];
        k    = m_k[id];
        len  = (kind == 0) ? 0 : lat(id, kind);
        word = ref_mem[id][m_addr[id][9:2]];
        fmt  = m_ws[id] ? {16'h0, m_addr[id][1] ? word[31:16] : word[15:0]} : word;
        e_cs = (kind == 1 && k == len - 1) || (kind == 2 && k == len);
        e_we = (kind == 2 && k == len);
        done = (kind != 0 && k == len);
        e_be = !e_cs ? 4'h0 : (kind == 1 || !m_ws[id]) ? 4'hF : (m_addr[id][1] ? 4'hC : 4'h3);
        e_wd = !e_we ? 32'h0 : (m_ws[id] ? {2{m_wd[id][15:0]}} : m_wd[id]);
        e_rd = (kind == 1 && done) ? fmt : m_hold[id];

        check("busy", 32'(busy[id]), 32'((kind == 1 && k < len) || (kind == 2 && k < len)));
        check("valid", 32'(valid[id]), 32'(kind == 1 && done));
        check("write_ready", 32'(ready[id]), 32'(e_we));
        check("sram_cs", 32'(cs[id]), 32'(e_cs));
        check("sram_we", 32'(we[id]), 32'(e_we));
        check("sram_be", 32'(be[id]), 32'(e_be));
        if (e_we || !(kind == 1 && k >= len - 1)) check("sram_wdata", swd[id], e_wd);
        if (e_cs) check("sram_addr", 32'(saddr[id]), 32'(m_addr[id][15:2]));
        check("read_data", rdo[id], e_rd);

        if (e_we)
            for (int b = 0; b < 4; b++)
                if (e_be[b]) ref_mem[id][m_addr[id][9:2]][8*b +: 8] = e_wd[8*b +: 8];
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                m_kind[j] = 0; m_k[j] = 0; m_hold[j] = 32'h0;
            end
        end else begin
            if (done && kind == 1) m_hold[id] = fmt;
            if ((kind == 0 || done) && (rd[id] || wr[id])) begin
                m_kind[id] = wr[id] ? 2 : 1;
                m_k[id]    = 1;
                m_addr[id] = addr[id];
                m_ws[id]   = ws[id];
                m_wd[id]   = wd[id];
            end else if (done) begin
                m_kind[id] = 0;
            end else if (kind != 0) begin
                m_k[id] = k + 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic random_run(input int id, input int n);
        int r;
        for (int c = 0; c < n; c++) begin
            r = $urandom_range(0, 9);
            set_req(id, (r >= 4 && r <= 6) || r == 9, r >= 7, 16'($urandom_range(0, 1023)),
                    1'($urandom_range(0, 1)), $urandom);
            step(id);
        end
        set_idle(id);
    endtask

    // Issue one request on instance 1 and measure completion cycle and busy cycles,
    // presenting junk writes while busy (these must be ignored).
    task automatic latency_probe(input logic is_wr, input int exp_t, input int exp_busy);
        int t, n;
        logic done_seen;
        set_req(1, !is_wr, is_wr, 16'h0088, 1'b0, 32'h0BAD_F00D);
        step(1);
        t = 1; n = 0;
        done_seen = is_wr ? ready[1] : valid[1];
        while (!done_seen && t < 12) begin
            n += busy[1] ? 1 : 0;
            set_req(1, 1'b0, 1'b1, 16'(($urandom_range(0, 255)) << 2), 1'b0, $urandom);
            step(1);
            t++;
            done_seen = is_wr ? ready[1] : valid[1];
        end
        set_idle(1);
        check(is_wr ? "wr_done_cycle" : "rd_done_cycle", 32'(t), 32'(exp_t));
        check(is_wr ? "wr_busy_cycles" : "rd_busy_cycles", 32'(n), 32'(exp_busy));
        step(1);
    endtask

    logic [31:0] tmp;

    initial begin
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 256; i++) ref_mem[j][i] = init_word(i);
            m_kind[j] = 0; m_k[j] = 0; m_hold[j] = 32'h0;
            m_addr[j] = 16'h0; m_ws[j] = 1'b0; m_wd[j] = 32'h0;
            set_idle(j);
        end
        reset = 1'b1;
        mem_init = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        reset = 1'b0;

        check("rst_sram_addr0", 32'(saddr[0]), 32'h0);
        check("rst_sram_addr1", 32'(saddr[1]), 32'h0);
        step(1);
        step(0);

        // Word write 0xDEADBEEF to 0x0040, then word read.
        set_req(0, 1'b0, 1'b1, 16'h0040, 1'b0, 32'hDEADBEEF); step(0);
        set_idle(0); step(0);
        set_req(0, 1'b1, 1'b0, 16'h0040, 1'b0, 32'h0); step(0);
        set_idle(0);
        check("rd_access_saddr", 32'(saddr[0]), 32'h10);
        step(0);
        check("word_read", rdo[0], 32'hDEADBEEF);
        // Back-to-back halfword reads issued in RD_DONE.
        set_req(0, 1'b1, 1'b0, 16'h0042, 1'b1, 32'h0); step(0);
        set_idle(0);
        check("b2b_busy", 32'(busy[0]), 32'h1);
        step(0);
        check("half_hi_read", rdo[0], 32'h0000DEAD);
        set_req(0, 1'b1, 1'b0, 16'h0040, 1'b1, 32'h0); step(0);
        set_idle(0); step(0);
        check("half_lo_read", rdo[0], 32'h0000BEEF);
        step(0);
        check("read_hold", rdo[0], 32'h0000BEEF);
        step(0);

        // Halfword write to the upper half of word 0x11, then word read of it.
        set_req(0, 1'b0, 1'b1, 16'h0046, 1'b1, 32'h1234ABCD); step(0);
        set_idle(0);
        check("hw_be", 32'(be[0]), 32'hC);
        check("hw_wdata", swd[0], 32'hABCDABCD);
        step(0);
        set_req(0, 1'b1, 1'b0, 16'h0044, 1'b0, 32'h0); step(0);
        set_idle(0); step(0);
        tmp = init_word(17);
        check("hw_merge_read", rdo[0], {16'hABCD, tmp[15:0]});
        step(0);

        // Collision: write wins, no valid pulse.
        set_req(0, 1'b1, 1'b1, 16'h0080, 1'b0, 32'hCAFEF00D); step(0);
        set_idle(0);
        check("coll_ready", 32'(ready[0]), 32'h1);
        check("coll_valid", 32'(valid[0]), 32'h0);
        step(0);
        step(0);

        random_run(0, 300);
        step(0);

        // Longer latencies on instance 1.
        latency_probe(1'b0, 4, 3);
        latency_probe(1'b1, 3, 2);

        // Reset in the middle of a read's wait phase.
        set_req(1, 1'b1, 1'b0, 16'h0040, 1'b0, 32'h0); step(1);
        set_idle(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_saddr", 32'(saddr[1]), 32'h0);
        for (int c = 0; c < 5; c++) step(1);

        random_run(1, 200);
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the fetch/decoder memory handshake: accepts one read or write request at a time from the access controller, drives a synchronous single-port SRAM, and returns mem_busy / mem_output_valid / mem_write_ready.
- Supports 32-bit word accesses (decoder) and 16-bit halfword accesses (instruction fetch), with programmable wait states.
- Sits between the controller's address/read-enable/word-select muxes and the SRAM macro.

Parameters:
- ADDR_WIDTH, 16, byte address width.
- READ_LATENCY, 2, cycles from the accept edge to the mem_output_valid_out pulse; must be >= 2.
- WRITE_LATENCY, 1, cycles from the accept edge to the mem_write_ready_out pulse; must be >= 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr_in  in  ADDR_WIDTH  byte address of the request.
- read_en_in  in  1  read request.
- write_en_in  in  1  write request.
- word_select_in  in  1  1 = halfword, 0 = word.
- write_data_in  in  32  store data; halfword uses [15:0].
- read_data_out  out  32  formatted read data.
- mem_busy_out  out  1  responder cannot accept a request this cycle.
- mem_output_valid_out  out  1  one-cycle read-complete pulse.
- mem_write_ready_out  out  1  one-cycle write-complete pulse.
- sram_addr_out  out  ADDR_WIDTH-2  SRAM word address.
- sram_cs_out  out  1  SRAM chip select.
- sram_we_out  out  1  SRAM write enable.
- sram_be_out  out  4  SRAM byte enables.
- sram_wdata_out  out  32  SRAM write data.
- sram_rdata_in  in  32  SRAM read data, valid the cycle after a cs-without-we cycle.

Behaviour:
- States: IDLE, RD_WAIT, RD_ACCESS, RD_DONE, WR_WAIT, WR_ACCESS. A wait-state counter of width clog2(max latency)+1 is loaded on accept.
- Accept rule: a request is sampled at a rising edge when the state is IDLE, RD_DONE or WR_ACCESS (mem_busy_out=0). Requests in any other state are ignored, not queued.
  - If read_en_in and write_en_in are both high, the write wins and the read is dropped.
  - addr_in, word_select_in and write_data_in are latched on accept.
- Read sequence, with the accept edge ending cycle 0:
  - RD_WAIT for READ_LATENCY-2 cycles (skipped when 0).
  - RD_ACCESS for 1 cycle: sram_cs_out=1, sram_we_out=0, sram_be_out=4'b1111, sram_addr_out=latched addr[ADDR_WIDTH-1:2].
  - RD_DONE for 1 cycle: mem_output_valid_out=1 in cycle READ_LATENCY.
- Read formatting in RD_DONE:
  - Word: read_data_out = sram_rdata_in.
  - Halfword: read_data_out = {16'h0, addr[1] ? rdata[31:16] : rdata[15:0]}.
  - The formatted value is also captured into a hold register. Outside RD_DONE, read_data_out shows the hold register.
- Write sequence:
  - WR_WAIT for WRITE_LATENCY-1 cycles.
  - WR_ACCESS for 1 cycle: sram_cs_out=1, sram_we_out=1, mem_write_ready_out=1 in cycle WRITE_LATENCY.
  - Word write: sram_be_out=4'b1111, sram_wdata_out=write_data_in.
  - Halfword write: sram_be_out = addr[1] ? 4'b1100 : 4'b0011, sram_wdata_out={wd[15:0],wd[15:0]}.
- Alignment: addr[1:0] is ignored for word accesses and addr[0] is ignored for halfword accesses. Misaligned addresses are silently aligned down; no error is flagged.
- mem_busy_out=1 in RD_WAIT, RD_ACCESS and WR_WAIT; 0 otherwise. Back-to-back operation: a request presented during RD_DONE or WR_ACCESS is accepted with no bubble.
- From RD_DONE or WR_ACCESS with no new request, the next state is IDLE.
- In IDLE, RD_WAIT and WR_WAIT: sram_cs_out=0, sram_we_out=0, sram_be_out=0, sram_wdata_out=0.
- Reset (synchronous, highest priority, valid at any time including mid-access):
  - state=IDLE, counter=0, hold register=0.
  - read_data_out=0, mem_busy_out=0, mem_output_valid_out=0, mem_write_ready_out=0.
  - sram_cs_out=0, sram_we_out=0, sram_be_out=0, sram_addr_out=0.
  - The in-flight access is aborted: no SRAM write and no completion pulse occur after the reset cycle.

Test Plan:
- Word read, READ_LATENCY=2: SRAM word 0x10 holds 0xDEADBEEF; read_en=1, addr=0x0040, word_select=0 in cycle 0 -> cycle 1: busy=1, cs=1, sram_addr=0x10; cycle 2: valid=1, read_data_out=0xDEADBEEF; held thereafter.
- Halfword reads: same word, addr=0x0042 then 0x0040, word_select=1, issued back-to-back in the RD_DONE cycle -> read_data_out=0x0000DEAD, then 0x0000BEEF; no idle cycle between the two accesses.
- Halfword write: write_en=1, addr=0x0046, wd=0x1234ABCD, WRITE_LATENCY=1 -> cycle 1: cs=1, we=1, be=4'b1100, wdata=0xABCDABCD, write_ready=1; a subsequent word read of 0x0044 returns 0xABCD<previous low half>.
- Latency sweep: READ_LATENCY=4, WRITE_LATENCY=3 -> valid in cycle 4 and write_ready in cycle 3; busy=1 in exactly 3 and 2 cycles respectively; requests during busy are ignored.
- Collision: read_en=1 and write_en=1 together -> write performed, no valid pulse. Reset asserted during RD_WAIT -> next cycle all outputs 0, no valid pulse, and the next request is accepted normally.
